sprite_anim_engine: RTL and testbench
=====================================

// Module: sprite_anim_engine
// PURPOSE
// Parametrised draw/erase/move sequencer for the 160x120 VGA snake game. Owns a movable player block and a
// loadable target (apple) block, both XDIM x YDIM pixels, and streams pixel writes to vga_adapter.
// Adds wrap/clamp edge modes, a latched direction with reversal rejection, target relocation and overlap (hit) detection.
// PARAMETERS
// XW       8    x coordinate width
// YW       7    y coordinate width
// CW       3    colour width
// XSCREEN  160  screen width; XSCREEN <= 2**XW
// YSCREEN  120  screen height; YSCREEN <= 2**YW
// XDIM     10   block width, pixels
// YDIM     10   block height, pixels
// STEP     1    pixels moved per tick
// WRAP     0    0 = clamp at edges; 1 = wrap to the opposite edge
// X0/Y0    39/59  player reset position
// XT0/YT0  80/60  target reset position
// BG       0    erase colour
// PORTS
// Clock      in   1    system clock
// Resetn     in   1    synchronous active-low reset
// start      in   1    leave IDLE and begin the draw loop
// tick       in   1    one-cycle animation pulse; sampled only in WAIT
// dir_valid  in   1    dir is valid this cycle
// dir        in   2    00 right, 01 down, 10 up, 11 left
// tgt_load   in   1    request to relocate the target to tgt_x/tgt_y
// tgt_x      in   XW   new target x
// tgt_y      in   YW   new target y
// colour_p   in   CW   player colour
// colour_t   in   CW   target colour
// vga_x      out  XW   pixel x
// vga_y      out  YW   pixel y
// vga_colour out  CW   pixel colour
// plot       out  1    pixel write strobe
// busy       out  1    1 in every state except IDLE and WAIT
// hit        out  1    one-cycle pulse: player overlaps target after a move
// edge_hit   out  1    one-cycle pulse: move clamped (WRAP=0) or wrapped (WRAP=1)
// pos_x      out  XW   player x
// pos_y      out  YW   player y
// BEHAVIOUR
// - Reset (Resetn=0 at posedge): state=IDLE, pos=(X0,Y0), target=(XT0,YT0), dir=00, moving=0, pending target cleared,
//   counters=0, hit=edge_hit=0. Reset overrides any in-progress operation.
// - States: IDLE -start-> DRAW_T -> DRAW_P -> WAIT -tick-> ERASE_P -> MOVE -> (pending ? ERASE_T -> DRAW_T : DRAW_T).
// - DRAW_T, DRAW_P, ERASE_P, ERASE_T each last exactly XDIM*YDIM cycles, row-major (xc inner), no dead cycles.
//   plot=1 in every one of those cycles. vga_x = base_x + xc and vga_y = base_y + yc (mod 2**XW / 2**YW).
// - Colours: DRAW_T uses colour_t, DRAW_P uses colour_p, erase states use BG.
// - Outside draw/erase states: plot=0, vga_x=0, vga_y=0, vga_colour=0. These outputs are combinational from state/counters.
// - Direction: on dir_valid, in any state, dir is latched and moving is set, unless the new dir is the reverse of the
//   current dir while moving=1 (00<->11, 01<->10); a reversal is ignored.
// - Target relocation: tgt_load captures tgt_x/tgt_y into a pending register (last request wins).
//   ERASE_T erases the old target; the new position takes effect on ERASE_T exit.
// - MOVE (1 cycle): if moving=0, position is unchanged. Otherwise the position steps STEP in dir.
//   - WRAP=0: result is clamped to [0, XSCREEN-XDIM] x [0, YSCREEN-YDIM]; edge_hit when clamped.
//   - WRAP=1: an exit past the max edge goes to 0, an exit past 0 goes to the max edge; edge_hit on wrap.
//   - Arithmetic is done one bit wider than XW/YW to detect over/underflow.
// - hit and edge_hit are registered and assert in the cycle after MOVE. Overlap test uses the new player position against
//   the current (pre-pending) target: px<tx+XDIM && tx<px+XDIM && py<ty+YDIM && ty<py+YDIM.
// - start is ignored outside IDLE. tick is ignored outside WAIT. Simultaneous tick and dir_valid: the dir latch applies first.
// TESTING
// 1. Reset, start pulse -> 100 plots at x80..89/y60..69 in colour_t, then 100 plots at x39..48/y59..68 in colour_p, then WAIT with busy=0.
// 2. dir_valid dir=00, tick -> 100 BG plots at the old player area, pos_x=40, DRAW_T then DRAW_P redraws at x40..49.
// 3. Moving right, then dir_valid dir=11 -> ignored; next tick gives pos_x+1. Then dir=01 is accepted; next tick gives pos_y+1.
// 4. WRAP=0, pos_x=150, moving right, tick -> pos_x stays 150, edge_hit=1 for 1 cycle. WRAP=1 -> pos_x=0, edge_hit=1.
// 5. Target (49,59), player (39,59) moving right, tick -> pos_x=40, hit=1 for one cycle. tgt_load (0,0) -> ERASE_T at x49..58, then DRAW_T at 0..9.
// 6. Resetn=0 midway through DRAW_P -> next cycle plot=0, state IDLE, pos=(39,59), dir=00, moving=0.

Source files
------------

// File: rtl/sprite_anim_engine.sv
// Draw/erase/move sequencer for a player block and a relocatable target block.
// Streams one pixel write per cycle, row-major, to a VGA frame-buffer adapter.
module sprite_anim_engine #(
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120,
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int STEP    = 1,
    parameter int WRAP    = 0,
    parameter int X0      = 39,
    parameter int Y0      = 59,
    parameter int XT0     = 80,
    parameter int YT0     = 60,
    parameter int BG      = 0
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    input  logic          tick,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    input  logic          tgt_load,
    input  logic [XW-1:0] tgt_x,
    input  logic [YW-1:0] tgt_y,
    input  logic [CW-1:0] colour_p,
    input  logic [CW-1:0] colour_t,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          plot,
    output logic          busy,
    output logic          hit,
    output logic          edge_hit,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y
);

    localparam int XCW = (XDIM > 1) ? $clog2(XDIM) : 1;
    localparam int YCW = (YDIM > 1) ? $clog2(YDIM) : 1;
    localparam logic [XW:0] XMAX  = (XW+1)'(XSCREEN - XDIM);
    localparam logic [YW:0] YMAX  = (YW+1)'(YSCREEN - YDIM);
    localparam logic [XW:0] XDW   = (XW+1)'(XDIM);
    localparam logic [YW:0] YDW   = (YW+1)'(YDIM);
    localparam logic [XW:0] XSTEP = (XW+1)'(STEP);
    localparam logic [YW:0] YSTEP = (YW+1)'(STEP);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAW_T, S_DRAW_P, S_WAIT, S_ERASE_P, S_MOVE, S_ERASE_T
    } state_t;

    state_t         state_q, state_d;
    logic [XCW-1:0] xc_q;
    logic [YCW-1:0] yc_q;
    logic [XW-1:0]  pos_x_q, pos_x_d, tgt_x_q, ptx_q;
    logic [YW-1:0]  pos_y_q, pos_y_d, tgt_y_q, pty_q;
    logic [1:0]     dir_q;
    logic           moving_q, pend_q;
    logic           hit_q, hit_d, ehit_q, ehit_d;
    logic [XW:0]    xw;
    logic [YW:0]    yw;
    logic           in_blk, xc_last, blk_last;

    assign in_blk   = (state_q == S_DRAW_T) || (state_q == S_DRAW_P) ||
                      (state_q == S_ERASE_P) || (state_q == S_ERASE_T);
    assign xc_last  = (xc_q == XCW'(XDIM - 1));
    assign blk_last = xc_last && (yc_q == YCW'(YDIM - 1));

    always_ff @(posedge Clock) begin
        if (!Resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start)    state_d = S_DRAW_T;
            S_DRAW_T:  if (blk_last) state_d = S_DRAW_P;
            S_DRAW_P:  if (blk_last) state_d = S_WAIT;
            S_WAIT:    if (tick)     state_d = S_ERASE_P;
            S_ERASE_P: if (blk_last) state_d = S_MOVE;
            S_MOVE:    state_d = pend_q ? S_ERASE_T : S_DRAW_T;
            S_ERASE_T: if (blk_last) state_d = S_DRAW_T;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        plot       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        busy       = (state_q != S_IDLE) && (state_q != S_WAIT);
        unique case (state_q)
            S_DRAW_T, S_ERASE_T: begin
                plot       = 1'b1;
                vga_x      = tgt_x_q + XW'(xc_q);
                vga_y      = tgt_y_q + YW'(yc_q);
                vga_colour = (state_q == S_DRAW_T) ? colour_t : CW'(BG);
            end
            S_DRAW_P, S_ERASE_P: begin
                plot       = 1'b1;
                vga_x      = pos_x_q + XW'(xc_q);
                vga_y      = pos_y_q + YW'(yc_q);
                vga_colour = (state_q == S_DRAW_P) ? colour_p : CW'(BG);
            end
            default: ;
        endcase
    end

    // One extra bit catches stepping past either screen edge.
    always_comb begin
        xw     = {1'b0, pos_x_q};
        yw     = {1'b0, pos_y_q};
        ehit_d = 1'b0;
        if (moving_q) begin
            unique case (dir_q)
                2'b00: begin
                    xw = {1'b0, pos_x_q} + XSTEP;
                    if (xw > XMAX) begin
                        ehit_d = 1'b1;
                        xw     = (WRAP != 0) ? '0 : XMAX;
                    end
                end
                2'b11: begin
                    xw = {1'b0, pos_x_q} - XSTEP;
                    if (xw[XW]) begin
                        ehit_d = 1'b1;
                        xw     = (WRAP != 0) ? XMAX : '0;
                    end
                end
                2'b01: begin
                    yw = {1'b0, pos_y_q} + YSTEP;
                    if (yw > YMAX) begin
                        ehit_d = 1'b1;
                        yw     = (WRAP != 0) ? '0 : YMAX;
                    end
                end
                2'b10: begin
                    yw = {1'b0, pos_y_q} - YSTEP;
                    if (yw[YW]) begin
                        ehit_d = 1'b1;
                        yw     = (WRAP != 0) ? YMAX : '0;
                    end
                end
            endcase
        end
        pos_x_d = xw[XW-1:0];
        pos_y_d = yw[YW-1:0];
    end

    assign hit_d = ({1'b0, pos_x_d} < {1'b0, tgt_x_q} + XDW) &&
                   ({1'b0, tgt_x_q} < {1'b0, pos_x_d} + XDW) &&
                   ({1'b0, pos_y_d} < {1'b0, tgt_y_q} + YDW) &&
                   ({1'b0, tgt_y_q} < {1'b0, pos_y_d} + YDW);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            xc_q     <= '0;
            yc_q     <= '0;
            pos_x_q  <= XW'(X0);
            pos_y_q  <= YW'(Y0);
            tgt_x_q  <= XW'(XT0);
            tgt_y_q  <= YW'(YT0);
            ptx_q    <= '0;
            pty_q    <= '0;
            pend_q   <= 1'b0;
            dir_q    <= 2'b00;
            moving_q <= 1'b0;
            hit_q    <= 1'b0;
            ehit_q   <= 1'b0;
        end else begin
            if (in_blk) begin
                if (xc_last) begin
                    xc_q <= '0;
                    yc_q <= blk_last ? '0 : yc_q + 1'b1;
                end else begin
                    xc_q <= xc_q + 1'b1;
                end
            end else begin
                xc_q <= '0;
                yc_q <= '0;
            end
            if (dir_valid && !(moving_q && ((dir ^ dir_q) == 2'b11))) begin
                dir_q    <= dir;
                moving_q <= 1'b1;
            end
            // A request arriving on the ERASE_T exit cycle stays pending.
            if (state_q == S_ERASE_T && blk_last) begin
                tgt_x_q <= ptx_q;
                tgt_y_q <= pty_q;
                pend_q  <= 1'b0;
            end
            if (tgt_load) begin
                ptx_q  <= tgt_x;
                pty_q  <= tgt_y;
                pend_q <= 1'b1;
            end
            if (state_q == S_MOVE) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
                hit_q   <= hit_d;
                ehit_q  <= ehit_d;
            end else begin
                hit_q  <= 1'b0;
                ehit_q <= 1'b0;
            end
        end
    end

    assign hit      = hit_q;
    assign edge_hit = ehit_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Directed bench for sprite_anim_engine: draw loop, moves, reversal,
// clamp/wrap edges, hit detection, target relocation and mid-draw reset.
module tb_sprite_anim_engine;

    logic       Clock = 1'b0;
    logic       Resetn, start, tick, dir_valid, tgt_load;
    logic [1:0] dir;
    logic [7:0] tgt_x;
    logic [6:0] tgt_y;
    logic [2:0] colour_p, colour_t;

    logic [7:0] vga_x, c_vga_x, w_vga_x, pos_x, c_pos_x, w_pos_x;
    logic [6:0] vga_y, c_vga_y, w_vga_y, pos_y, c_pos_y, w_pos_y;
    logic [2:0] vga_colour, c_vga_colour, w_vga_colour;
    logic       plot, busy, hit, edge_hit;
    logic       c_plot, c_busy, c_hit, c_edge_hit;
    logic       w_plot, w_busy, w_hit, w_edge_hit;

    int checks = 0;
    int errors = 0;

    logic [7:0] gx [100];
    logic [6:0] gy [100];
    logic [2:0] gc [100];
    logic       gp [100];
    logic       gb [100];
    logic       gh [100];
    logic       ge [100];

    sprite_anim_engine dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir(dir), .tgt_load(tgt_load),
        .tgt_x(tgt_x), .tgt_y(tgt_y),
        .colour_p(colour_p), .colour_t(colour_t),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy), .hit(hit), .edge_hit(edge_hit),
        .pos_x(pos_x), .pos_y(pos_y)
    );

    sprite_anim_engine #(.X0(149), .WRAP(0)) dutc (
        .Clock(Clock), .Resetn(Resetn), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir(dir), .tgt_load(tgt_load),
        .tgt_x(tgt_x), .tgt_y(tgt_y),
        .colour_p(colour_p), .colour_t(colour_t),
        .vga_x(c_vga_x), .vga_y(c_vga_y), .vga_colour(c_vga_colour),
        .plot(c_plot), .busy(c_busy), .hit(c_hit), .edge_hit(c_edge_hit),
        .pos_x(c_pos_x), .pos_y(c_pos_y)
    );

    sprite_anim_engine #(.X0(149), .WRAP(1)) dutw (
        .Clock(Clock), .Resetn(Resetn), .start(start), .tick(tick),
        .dir_valid(dir_valid), .dir(dir), .tgt_load(tgt_load),
        .tgt_x(tgt_x), .tgt_y(tgt_y),
        .colour_p(colour_p), .colour_t(colour_t),
        .vga_x(w_vga_x), .vga_y(w_vga_y), .vga_colour(w_vga_colour),
        .plot(w_plot), .busy(w_busy), .hit(w_hit), .edge_hit(w_edge_hit),
        .pos_x(w_pos_x), .pos_y(w_pos_y)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(negedge Clock);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic grab();
        for (int i = 0; i < 100; i++) begin
            gx[i] = vga_x; gy[i] = vga_y; gc[i] = vga_colour;
            gp[i] = plot;  gb[i] = busy;
            gh[i] = hit;   ge[i] = edge_hit;
            @(negedge Clock);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        Resetn = 1'b0;
        run(2);
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || pos_x !== 8'd39 || pos_y !== 7'd59 ||
            hit !== 1'b0 || edge_hit !== 1'b0 || vga_x !== 8'd0 || vga_colour !== 3'd0) begin
            errors++;
            $display("FAIL reset_state plot=%0d busy=%0d pos=(%0d,%0d) hit=%0d edge=%0d x=%0d c=%0d required 0 0 (39,59) 0 0 0 0",
                     plot, busy, pos_x, pos_y, hit, edge_hit, vga_x, vga_colour);
        end
        Resetn = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(80 + i % 10) || gy[i] !== 7'(60 + i / 10) || gc[i] !== 3'd2 ||
                gp[i] !== 1'b1 || gb[i] !== 1'b1)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL first_draw_t px%0d got x=%0d y=%0d c=%0d plot=%0d busy=%0d required x=%0d y=%0d c=2 plot=1 busy=1",
                     bad, gx[bad], gy[bad], gc[bad], gp[bad], gb[bad], 80 + bad % 10, 60 + bad / 10);
        end
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(39 + i % 10) || gy[i] !== 7'(59 + i / 10) || gc[i] !== 3'd5 || gp[i] !== 1'b1)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL first_draw_p px%0d got x=%0d y=%0d c=%0d plot=%0d required x=%0d y=%0d c=5 plot=1",
                     bad, gx[bad], gy[bad], gc[bad], gp[bad], 39 + bad % 10, 59 + bad / 10);
        end
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0) begin
            errors++;
            $display("FAIL wait_idle_outputs busy=%0d plot=%0d x=%0d y=%0d required 0 0 0 0",
                     busy, plot, vga_x, vga_y);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            errors++;
            $display("FAIL start_in_wait busy=%0d plot=%0d required 0 0", busy, plot);
        end
    endtask

    task automatic test_first_move();
        int bad;
        dir_valid = 1'b1;
        dir       = 2'b00;
        tick      = 1'b1;
        step();
        dir_valid = 1'b0;
        tick      = 1'b0;
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(39 + i % 10) || gy[i] !== 7'(59 + i / 10) || gc[i] !== 3'd0 || gp[i] !== 1'b1)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL erase_p px%0d got x=%0d y=%0d c=%0d plot=%0d required x=%0d y=%0d c=0 plot=1",
                     bad, gx[bad], gy[bad], gc[bad], gp[bad], 39 + bad % 10, 59 + bad / 10);
        end
        checks++;
        if (plot !== 1'b0 || busy !== 1'b1 || vga_x !== 8'd0) begin
            errors++;
            $display("FAIL move_cycle plot=%0d busy=%0d x=%0d required 0 1 0", plot, busy, vga_x);
        end
        step();
        checks++;
        if (pos_x !== 8'd40 || pos_y !== 7'd59) begin
            errors++;
            $display("FAIL move_right pos=(%0d,%0d) required (40,59)", pos_x, pos_y);
        end
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(80 + i % 10) || gy[i] !== 7'(60 + i / 10) || gc[i] !== 3'd2 ||
                gh[i] !== 1'b0 || ge[i] !== 1'b0)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL redraw_t px%0d got x=%0d y=%0d c=%0d hit=%0d edge=%0d required x=%0d y=%0d c=2 hit=0 edge=0",
                     bad, gx[bad], gy[bad], gc[bad], gh[bad], ge[bad], 80 + bad % 10, 60 + bad / 10);
        end
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(40 + i % 10) || gy[i] !== 7'(59 + i / 10) || gc[i] !== 3'd5)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL redraw_p px%0d got x=%0d y=%0d c=%0d required x=%0d y=%0d c=5",
                     bad, gx[bad], gy[bad], gc[bad], 40 + bad % 10, 59 + bad / 10);
        end
    endtask

    task automatic test_reversal();
        dir_valid = 1'b1;
        dir       = 2'b11;
        step();
        dir_valid = 1'b0;
        pulse_tick();
        run(101);
        checks++;
        if (pos_x !== 8'd41 || pos_y !== 7'd59) begin
            errors++;
            $display("FAIL reverse_ignored pos=(%0d,%0d) required (41,59)", pos_x, pos_y);
        end
        tick = 1'b1;
        run(200);
        tick = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tick_outside_wait busy=%0d required 0", busy);
        end
        dir_valid = 1'b1;
        dir       = 2'b01;
        step();
        dir_valid = 1'b0;
        pulse_tick();
        run(101);
        checks++;
        if (pos_x !== 8'd41 || pos_y !== 7'd60) begin
            errors++;
            $display("FAIL turn_down pos=(%0d,%0d) required (41,60)", pos_x, pos_y);
        end
        run(200);
        dir_valid = 1'b1;
        dir       = 2'b10;
        step();
        dir_valid = 1'b0;
        pulse_tick();
        run(101);
        checks++;
        if (pos_x !== 8'd41 || pos_y !== 7'd61) begin
            errors++;
            $display("FAIL up_reverse_ignored pos=(%0d,%0d) required (41,61)", pos_x, pos_y);
        end
        run(200);
    endtask

    task automatic test_edges();
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        run(200);
        dir_valid = 1'b1;
        dir       = 2'b00;
        step();
        dir_valid = 1'b0;
        pulse_tick();
        run(101);
        checks++;
        if (c_pos_x !== 8'd150 || w_pos_x !== 8'd150 || c_edge_hit !== 1'b0 || w_edge_hit !== 1'b0) begin
            errors++;
            $display("FAIL approach_edge clamp_x=%0d wrap_x=%0d edges=%0d%0d required 150 150 00",
                     c_pos_x, w_pos_x, c_edge_hit, w_edge_hit);
        end
        run(200);
        pulse_tick();
        run(101);
        checks++;
        if (c_pos_x !== 8'd150 || c_edge_hit !== 1'b1) begin
            errors++;
            $display("FAIL clamp_right x=%0d edge=%0d required 150 1", c_pos_x, c_edge_hit);
        end
        checks++;
        if (w_pos_x !== 8'd0 || w_edge_hit !== 1'b1 || w_pos_y !== 7'd59) begin
            errors++;
            $display("FAIL wrap_right pos=(%0d,%0d) edge=%0d required (0,59) 1", w_pos_x, w_pos_y, w_edge_hit);
        end
        checks++;
        if (pos_x !== 8'd41 || edge_hit !== 1'b0) begin
            errors++;
            $display("FAIL interior_move x=%0d edge=%0d required 41 0", pos_x, edge_hit);
        end
        step();
        checks++;
        if (c_edge_hit !== 1'b0 || w_edge_hit !== 1'b0) begin
            errors++;
            $display("FAIL edge_pulse_len clamp=%0d wrap=%0d required 0 0", c_edge_hit, w_edge_hit);
        end
        run(199);
    endtask

    task automatic test_hit_and_relocate();
        int bad;
        Resetn = 1'b0;
        step();
        Resetn   = 1'b1;
        tgt_x    = 8'd49;
        tgt_y    = 7'd59;
        tgt_load = 1'b1;
        step();
        tgt_load = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        grab();
        checks++;
        if (gx[0] !== 8'd80 || gy[0] !== 7'd60 || gx[99] !== 8'd89 || gy[99] !== 7'd69) begin
            errors++;
            $display("FAIL pending_not_early first=(%0d,%0d) last=(%0d,%0d) required (80,60) (89,69)",
                     gx[0], gy[0], gx[99], gy[99]);
        end
        run(100);
        pulse_tick();
        run(101);
        checks++;
        if (pos_x !== 8'd39 || pos_y !== 7'd59) begin
            errors++;
            $display("FAIL idle_move pos=(%0d,%0d) required (39,59)", pos_x, pos_y);
        end
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(80 + i % 10) || gy[i] !== 7'(60 + i / 10) || gc[i] !== 3'd0 ||
                gp[i] !== 1'b1 || gh[i] !== 1'b0)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL erase_t_old px%0d got x=%0d y=%0d c=%0d plot=%0d hit=%0d required x=%0d y=%0d c=0 plot=1 hit=0",
                     bad, gx[bad], gy[bad], gc[bad], gp[bad], gh[bad], 80 + bad % 10, 60 + bad / 10);
        end
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(49 + i % 10) || gy[i] !== 7'(59 + i / 10) || gc[i] !== 3'd2)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL draw_t_new px%0d got x=%0d y=%0d c=%0d required x=%0d y=%0d c=2",
                     bad, gx[bad], gy[bad], gc[bad], 49 + bad % 10, 59 + bad / 10);
        end
        run(100);
        dir_valid = 1'b1;
        dir       = 2'b00;
        step();
        dir_valid = 1'b0;
        pulse_tick();
        run(101);
        grab();
        checks++;
        if (gh[0] !== 1'b1 || gh[1] !== 1'b0 || pos_x !== 8'd40) begin
            errors++;
            $display("FAIL hit_pulse hit0=%0d hit1=%0d x=%0d required 1 0 40", gh[0], gh[1], pos_x);
        end
        run(100);
        tgt_x    = 8'd0;
        tgt_y    = 7'd0;
        tgt_load = 1'b1;
        step();
        tgt_load = 1'b0;
        pulse_tick();
        run(101);
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(49 + i % 10) || gy[i] !== 7'(59 + i / 10) || gc[i] !== 3'd0)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0 || gh[0] !== 1'b1) begin
            errors++;
            if (bad < 0) bad = 0;
            $display("FAIL erase_t_49 px%0d got x=%0d y=%0d c=%0d hit0=%0d required x=%0d y=%0d c=0 hit0=1",
                     bad, gx[bad], gy[bad], gc[bad], gh[0], 49 + bad % 10, 59 + bad / 10);
        end
        grab();
        bad = -1;
        for (int i = 0; i < 100; i++)
            if (gx[i] !== 8'(i % 10) || gy[i] !== 7'(i / 10) || gc[i] !== 3'd2)
                if (bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL draw_t_origin px%0d got x=%0d y=%0d c=%0d required x=%0d y=%0d c=2",
                     bad, gx[bad], gy[bad], gc[bad], bad % 10, bad / 10);
        end
        run(100);
    endtask

    task automatic test_reset_mid_draw();
        pulse_tick();
        run(101);
        tgt_x    = 8'd5;
        tgt_y    = 7'd5;
        tgt_load = 1'b1;
        step();
        tgt_load = 1'b0;
        run(149);
        checks++;
        if (plot !== 1'b1 || vga_colour !== 3'd5 || pos_x !== 8'd42) begin
            errors++;
            $display("FAIL mid_draw_p plot=%0d c=%0d x=%0d required 1 5 42", plot, vga_colour, pos_x);
        end
        Resetn = 1'b0;
        step();
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || pos_x !== 8'd39 || pos_y !== 7'd59 || vga_x !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid plot=%0d busy=%0d pos=(%0d,%0d) x=%0d required 0 0 (39,59) 0",
                     plot, busy, pos_x, pos_y, vga_x);
        end
        Resetn = 1'b1;
        start  = 1'b1;
        step();
        start  = 1'b0;
        grab();
        checks++;
        if (gx[0] !== 8'd80 || gy[0] !== 7'd60 || gc[0] !== 3'd2) begin
            errors++;
            $display("FAIL target_reset got (%0d,%0d) c=%0d required (80,60) c=2", gx[0], gy[0], gc[0]);
        end
        run(100);
        pulse_tick();
        run(101);
        grab();
        checks++;
        if (pos_x !== 8'd39 || gx[0] !== 8'd80 || gc[0] !== 3'd2) begin
            errors++;
            $display("FAIL moving_pending_cleared x=%0d tx=%0d c=%0d required 39 80 2", pos_x, gx[0], gc[0]);
        end
        run(100);
        dir_valid = 1'b1;
        dir       = 2'b11;
        step();
        dir_valid = 1'b0;
        pulse_tick();
        run(101);
        checks++;
        if (pos_x !== 8'd38 || pos_y !== 7'd59) begin
            errors++;
            $display("FAIL left_after_reset pos=(%0d,%0d) required (38,59)", pos_x, pos_y);
        end
        run(200);
    endtask

    initial begin
        Resetn    = 1'b0;
        start     = 1'b0;
        tick      = 1'b0;
        dir_valid = 1'b0;
        dir       = 2'b00;
        tgt_load  = 1'b0;
        tgt_x     = 8'd0;
        tgt_y     = 7'd0;
        colour_p  = 3'd5;
        colour_t  = 3'd2;
        step();
        test_reset();
        test_first_move();
        test_reversal();
        test_edges();
        test_hit_and_relocate();
        test_reset_mid_draw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
